show_rect_overlay_n: RTL and testbench
======================================

Name: show_rect_overlay_n

Overview:
- Parametrised next-generation rectangle overlay for the post-processing video chain. Operates on the RGB565 pixel stream ahead of the display encoder.
- Draws up to RECT_N rectangles per frame. Each rectangle has its own mode (off / outline / solid fill / 50% blend), palette colour and outline thickness.
- Configuration is double-buffered and committed only at frame start, so a frame never shows a half-updated set of rectangles.

Parameters:
- RECT_N, 8: number of rectangle channels. Lower index has higher drawing priority.
- P_W, 11: coordinate width (`POSITION_WIDTH).
- IMG_W, 1280: active pixels per line.
- IMG_H, 720: active lines per frame.
- PIX_W, 16: pixel width (RGB565).

Ports:
- sys_clk, in, 1: pixel clock.
- sys_rst, in, 1: reset, asynchronous, active-high.
- i_start, in, 1: one-cycle strobe; captures i_rect_wire into the shadow bank.
- i_rect_wire, in, RECT_N*RB: per-rect record, where RB = 4*P_W+8. Fields from LSB: x1, y1, x2, y2 (each P_W), mode[1:0], color[2:0], thick[2:0].
- i_vs, in, 1: frame sync, level, active-high.
- i_valid, in, 1: pixel valid.
- i_data, in, PIX_W: input pixel.
- o_valid, out, 1: output pixel valid.
- o_data, out, PIX_W: overlaid pixel.
- o_data_raw, out, PIX_W: input pixel delayed to align with o_data.

Behaviour:
- Reset: every output is 0; x/y counters are 0; shadow and active banks are 0 (all rects mode 0 = off); the vs edge register is 0.
- Frame start is the registered rising edge of i_vs. On that cycle:
  - x and y are cleared to 0.
  - active bank <= shadow bank.
  - If i_start is asserted in the same cycle, active bank <= i_rect_wire directly (bypass), and shadow is also updated.
- i_start outside a frame start updates only the shadow bank. A later i_start before the next frame start overwrites it; the last one wins.
- Pixel counter:
  - Each i_valid cycle increments x.
  - When x == IMG_W-1, x wraps to 0 and y increments.
  - y saturates at IMG_H. While y == IMG_H, no overlay is applied (passthrough).
  - i_valid is ignored for counting while i_vs is high.
- Per-rect hit, computed in stage 1 using P_W+1-bit arithmetic with no underflow:
  - in = x1<=x<=x2 and y1<=y<=y2.
  - A rect with x1>x2 or y1>y2 is treated as off.
  - Effective thickness T = (thick==0) ? 1 : thick.
  - Outline hit = in and (x < x1+T or x+T > x2 or y < y1+T or y+T > y2).
  - Fill hit and blend hit = in.
- Priority: the lowest-index rect with a hit selects colour and mode; all others are ignored.
- Palette, 3-bit index to RGB565 constant: 0 black 0000, 1 red F800, 2 green 07E0, 3 blue 001F, 4 yellow FFE0, 5 cyan 07FF, 6 magenta F81F, 7 white FFFF.
- Stage 2 output pixel:
  - No hit: pixel unchanged.
  - Outline/fill: palette colour.
  - Blend: ((pix>>1) & 7BEF) + ((col>>1) & 7BEF), i.e. per-channel average with no carry between fields.
- Latency is fixed at 2 cycles:
  - o_valid = i_valid delayed by 2.
  - o_data and o_data_raw are aligned with o_valid.
  - When o_valid=0, o_data and o_data_raw hold their last values.
- Reset mid-frame: the pipeline flushes, o_valid=0 immediately, and the overlay stays off until a new i_start plus frame start.
- Gaps in i_valid (blanking) do not advance the counters or pipeline data. The valid delay line still shifts every cycle.

Decomposition:
- Package show_rect_pkg holds:
  - RB and the field offsets;
  - MODE_OFF=0, MODE_OUTLINE=1, MODE_FILL=2, MODE_BLEND=3;
  - the 8-entry RGB565 palette constant;
  - BLEND_MASK=16'h7BEF.
- Sub-module rect_hit_unit, instantiated RECT_N times via generate. It takes x, y and one rect record and returns a registered hit flag plus mode and colour.
- The top holds the banks, the counters, the priority encoder and the blend stage.

Test Plan:
- Bench settings: IMG_W=16, IMG_H=8, RECT_N=4.
- Reset, then a frame with all rects off: o_data == o_data_raw == i_data delayed 2; o_valid == i_valid delayed 2.
- rect0 = (2,2)-(5,4), outline, red, thick=0: F800 at the border pixels, e.g. (2,3), (5,3), (3,2); interior (3,3) passes through; (1,3) passes through.
- rect0 fill green (0,0)-(3,3) and rect1 fill blue (2,2)-(6,6) overlapping: (2,2) = 07E0 (rect0 wins); (5,5) = 001F.
- Blend white over input pixel F800 → (7C00 & 7BEF) + 7BEF = 7800 + 7BEF = F3EF.
- i_start mid-frame with new coordinates: the current frame is unchanged and the new rect appears from the next i_vs rise. i_start on the i_vs-rise cycle takes effect in that same frame.
- Boundary cases:
  - x1>x2 record: no drawing.
  - Rect at (15,7)-(15,7) fill: only the last pixel changes.
  - Extra lines beyond IMG_H: passthrough.
  - sys_rst pulse mid-line: o_valid drops the same cycle.

Source files
------------

// File: rtl/show_rect_overlay_n_pkg.sv
// Shared definitions for the rectangle overlay: record layout, draw modes,
// RGB565 palette and the per-channel blend helper.
package show_rect_pkg;

    // Record layout: x1, y1, x2, y2 (each P_W bits) from the LSB, then attributes.
    localparam int unsigned P_W_DEF = 11;
    localparam int unsigned ATTR_W  = 8;
    localparam int unsigned RB      = 4 * P_W_DEF + ATTR_W;

    localparam int unsigned X1_OFS    = 0;
    localparam int unsigned Y1_OFS    = P_W_DEF;
    localparam int unsigned X2_OFS    = 2 * P_W_DEF;
    localparam int unsigned Y2_OFS    = 3 * P_W_DEF;
    localparam int unsigned ATTR_OFS  = 4 * P_W_DEF;

    // Record width for an arbitrary coordinate width.
    function automatic int unsigned rb_of(input int unsigned p_w);
        return 4 * p_w + ATTR_W;
    endfunction

    // Attribute byte, packed MSB-first so mode sits at the lowest bits.
    typedef struct packed {
        logic [2:0] thick;
        logic [2:0] color;
        logic [1:0] mode;
    } rect_attr_t;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_OUTLINE = 2'd1;
    localparam logic [1:0] MODE_FILL    = 2'd2;
    localparam logic [1:0] MODE_BLEND   = 2'd3;

    // Entry 0 at the LSB: black, red, green, blue, yellow, cyan, magenta, white.
    localparam logic [8*16-1:0] PALETTE = {
        16'hFFFF, 16'hF81F, 16'h07FF, 16'hFFE0,
        16'h001F, 16'h07E0, 16'hF800, 16'h0000
    };

    localparam logic [15:0] BLEND_MASK = 16'h7BEF;

    function automatic logic [15:0] palette_rgb(input logic [2:0] idx);
        return PALETTE[{idx, 4'h0} +: 16];
    endfunction

    // Halve each RGB565 field before adding so no carry crosses a field boundary.
    function automatic logic [15:0] blend565(input logic [15:0] pix, input logic [15:0] col);
        return ((pix >> 1) & BLEND_MASK) + ((col >> 1) & BLEND_MASK);
    endfunction

endpackage

// File: rtl/show_rect_overlay_n_if.sv
// Pixel stream and configuration bundle for show_rect_overlay_n.
//   slave  : overlay side (consumes i_*, produces o_*)
//   master : source/sink side
interface show_rect_overlay_n_if #(
    parameter int unsigned RECT_N = 8,
    parameter int unsigned P_W    = 11,
    parameter int unsigned PIX_W  = 16
);
    import show_rect_pkg::*;

    localparam int unsigned RW = 4 * P_W + ATTR_W;

    logic                   i_start;
    logic [RECT_N*RW-1:0]   i_rect_wire;
    logic                   i_vs;
    logic                   i_valid;
    logic [PIX_W-1:0]       i_data;
    logic                   o_valid;
    logic [PIX_W-1:0]       o_data;
    logic [PIX_W-1:0]       o_data_raw;

    modport master (
        output i_start, i_rect_wire, i_vs, i_valid, i_data,
        input  o_valid, o_data, o_data_raw
    );

    modport slave (
        input  i_start, i_rect_wire, i_vs, i_valid, i_data,
        output o_valid, o_data, o_data_raw
    );

endinterface

// File: rtl/show_rect_overlay_n_rect_hit.sv
// One rectangle channel: decides whether the current (x, y) is drawn by this
// rectangle and registers the result with the rectangle's mode and colour.
//   clk, rst : pixel clock, async active-high reset
//   en       : pixel valid; hold registered result otherwise
//   x, y     : current pixel position
//   rect     : record {attr, y2, x2, y1, x1}
//   hit, mode, color : registered stage-1 result
module rect_hit_unit
    import show_rect_pkg::*;
#(
    parameter int unsigned P_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [P_W-1:0]          x,
    input  logic [P_W-1:0]          y,
    input  logic [4*P_W+ATTR_W-1:0] rect,
    output logic                    hit,
    output logic [1:0]              mode,
    output logic [2:0]              color
);

    localparam int unsigned EW = P_W + 1;

    rect_attr_t    attr;
    logic [EW-1:0] x_e, y_e, x1_e, y1_e, x2_e, y2_e, t_e;
    logic          ordered_c, inside_c, border_c, hit_c;

    assign attr = rect[4*P_W +: ATTR_W];
    assign x_e  = {1'b0, x};
    assign y_e  = {1'b0, y};
    assign x1_e = {1'b0, rect[0*P_W +: P_W]};
    assign y1_e = {1'b0, rect[1*P_W +: P_W]};
    assign x2_e = {1'b0, rect[2*P_W +: P_W]};
    assign y2_e = {1'b0, rect[3*P_W +: P_W]};

    // Thickness 0 still draws a one-pixel outline.
    assign t_e = (attr.thick == 3'd0) ? EW'(1) : EW'(attr.thick);

    // Comparisons are arranged as sums only, so nothing can underflow.
    assign ordered_c = (x1_e <= x2_e) && (y1_e <= y2_e);
    assign inside_c  = (x_e >= x1_e) && (x_e <= x2_e) && (y_e >= y1_e) && (y_e <= y2_e);
    assign border_c  = (x_e < x1_e + t_e) || (x_e + t_e > x2_e) ||
                       (y_e < y1_e + t_e) || (y_e + t_e > y2_e);

    always_comb begin
        hit_c = 1'b0;
        if (ordered_c && attr.mode != MODE_OFF) begin
            hit_c = (attr.mode == MODE_OUTLINE) ? (inside_c && border_c) : inside_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit   <= 1'b0;
            mode  <= MODE_OFF;
            color <= 3'd0;
        end else if (en) begin
            hit   <= hit_c;
            mode  <= attr.mode;
            color <= attr.color;
        end
    end

endmodule

// File: rtl/show_rect_overlay_n.sv
// Multi-rectangle overlay on an RGB565 stream with frame-synchronous,
// double-buffered configuration and a fixed two-cycle latency.
//   sys_clk, sys_rst : pixel clock, async active-high reset
//   bus (slave)      : i_start/i_rect_wire config, i_vs/i_valid/i_data in,
//                      o_valid/o_data/o_data_raw out
module show_rect_overlay_n
    import show_rect_pkg::*;
#(
    parameter int unsigned RECT_N = 8,
    parameter int unsigned P_W    = 11,
    parameter int unsigned IMG_W  = 1280,
    parameter int unsigned IMG_H  = 720,
    parameter int unsigned PIX_W  = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    show_rect_overlay_n_if.slave bus
);

    localparam int unsigned RW     = rb_of(P_W);
    localparam int unsigned BANK_W = RECT_N * RW;

    logic               vs_q;
    logic               frame_start_c;
    logic [BANK_W-1:0]  shadow_bank;
    logic [BANK_W-1:0]  active_bank;
    logic [P_W-1:0]     x_cnt;
    logic [P_W-1:0]     y_cnt;

    logic               valid_s1;
    logic [PIX_W-1:0]   pix_s1;
    logic               pass_s1;
    logic [RECT_N-1:0]  hit_s1;
    logic [1:0]         mode_s1  [RECT_N];
    logic [2:0]         color_s1 [RECT_N];

    logic               sel_hit_c;
    logic [1:0]         sel_mode_c;
    logic [2:0]         sel_color_c;
    logic [PIX_W-1:0]   ovl_pix_c;

    assign frame_start_c = bus.i_vs & ~vs_q;

    // Frame sync edge register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) vs_q <= 1'b0;
        else         vs_q <= bus.i_vs;
    end

    // Shadow takes every i_start; active only changes at frame start, with a
    // same-cycle i_start bypassing the shadow.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shadow_bank <= '0;
            active_bank <= '0;
        end else begin
            if (bus.i_start) shadow_bank <= bus.i_rect_wire;
            if (frame_start_c) active_bank <= bus.i_start ? bus.i_rect_wire : shadow_bank;
        end
    end

    // Pixel position; y parks at IMG_H for any lines past the active area.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_start_c) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (bus.i_valid && !bus.i_vs) begin
            if (x_cnt == P_W'(IMG_W - 1)) begin
                x_cnt <= '0;
                if (y_cnt != P_W'(IMG_H)) y_cnt <= y_cnt + P_W'(1);
            end else begin
                x_cnt <= x_cnt + P_W'(1);
            end
        end
    end

    // Stage 1: per-rectangle hit tests.
    for (genvar g = 0; g < RECT_N; g++) begin : g_rect
        rect_hit_unit #(.P_W(P_W)) u_hit (
            .clk   (sys_clk),
            .rst   (sys_rst),
            .en    (bus.i_valid),
            .x     (x_cnt),
            .y     (y_cnt),
            .rect  (active_bank[g*RW +: RW]),
            .hit   (hit_s1[g]),
            .mode  (mode_s1[g]),
            .color (color_s1[g])
        );
    end

    // Stage 1: pixel and passthrough flag, held across blanking.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_s1 <= 1'b0;
            pix_s1   <= '0;
            pass_s1  <= 1'b0;
        end else begin
            valid_s1 <= bus.i_valid;
            if (bus.i_valid) begin
                pix_s1  <= bus.i_data;
                pass_s1 <= (y_cnt == P_W'(IMG_H));
            end
        end
    end

    // Priority select: scan high to low so the lowest index is left standing.
    always_comb begin
        sel_hit_c   = 1'b0;
        sel_mode_c  = MODE_OFF;
        sel_color_c = 3'd0;
        for (int i = int'(RECT_N) - 1; i >= 0; i--) begin
            if (hit_s1[i]) begin
                sel_hit_c   = 1'b1;
                sel_mode_c  = mode_s1[i];
                sel_color_c = color_s1[i];
            end
        end
    end

    always_comb begin
        ovl_pix_c = pix_s1;
        if (sel_hit_c && !pass_s1) begin
            if (sel_mode_c == MODE_BLEND)
                ovl_pix_c = PIX_W'(blend565(16'(pix_s1), palette_rgb(sel_color_c)));
            else
                ovl_pix_c = PIX_W'(palette_rgb(sel_color_c));
        end
    end

    // Stage 2: registered outputs; data holds while o_valid is low.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_data_raw <= '0;
        end else begin
            bus.o_valid <= valid_s1;
            if (valid_s1) begin
                bus.o_data     <= ovl_pix_c;
                bus.o_data_raw <= pix_s1;
            end
        end
    end

endmodule

// File: tb/tb_show_rect_overlay_n.sv
// Directed bench for show_rect_overlay_n with a reference pixel model and a
// scoreboard queue aligned to the two-cycle output latency.
module tb_show_rect_overlay_n;

    localparam int unsigned RECT_N = 4;
    localparam int unsigned P_W    = 11;
    localparam int unsigned IMG_W  = 16;
    localparam int unsigned IMG_H  = 8;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned RB     = 4 * P_W + 8;
    localparam int unsigned BW     = RECT_N * RB;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    show_rect_overlay_n_if #(.RECT_N(RECT_N), .P_W(P_W), .PIX_W(PIX_W)) bus ();

    show_rect_overlay_n #(
        .RECT_N(RECT_N), .P_W(P_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] data;
        logic [15:0] raw;
        int          x;
        int          y;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [BW-1:0] m_shadow = '0;
    logic [BW-1:0] m_active = '0;
    logic          m_vsq    = 1'b0;
    int            m_x      = 0;
    int            m_y      = 0;
    logic          ev1      = 1'b0;
    logic          ev2      = 1'b0;

    logic [15:0]   cap     [IMG_H][IMG_W];
    logic [15:0]   cap_raw [IMG_H][IMG_W];
    logic          const_en  = 1'b1;
    logic [15:0]   const_pix = 16'h1234;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [RB-1:0] mk(input int x1, input int y1, input int x2, input int y2,
                                         input int mode, input int col, input int thick);
        logic [RB-1:0] r;
        r = '0;
        r[10:0]  = 11'(x1);
        r[21:11] = 11'(y1);
        r[32:22] = 11'(x2);
        r[43:33] = 11'(y2);
        r[45:44] = 2'(mode);
        r[48:46] = 3'(col);
        r[51:49] = 3'(thick);
        return r;
    endfunction

    function automatic logic [15:0] pal(input int idx);
        case (idx)
            0: return 16'h0000;
            1: return 16'hF800;
            2: return 16'h07E0;
            3: return 16'h001F;
            4: return 16'hFFE0;
            5: return 16'h07FF;
            6: return 16'hF81F;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Per-field average of the halves of each colour component.
    function automatic logic [15:0] avg565(input logic [15:0] p, input logic [15:0] c);
        int r, g, b;
        r = int'(p[15:11]) / 2 + int'(c[15:11]) / 2;
        g = int'(p[10:5]) / 2 + int'(c[10:5]) / 2;
        b = int'(p[4:0]) / 2 + int'(c[4:0]) / 2;
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    function automatic logic [15:0] exp_pix(input logic [BW-1:0] bank, input int x, input int y,
                                            input logic [15:0] pix);
        logic [RB-1:0] rec;
        int x1, y1, x2, y2, mode, cidx, t;
        bit inr, hit;
        if (y >= int'(IMG_H)) return pix;
        for (int r = 0; r < int'(RECT_N); r++) begin
            rec  = bank[r*RB +: RB];
            x1   = int'(rec[10:0]);
            y1   = int'(rec[21:11]);
            x2   = int'(rec[32:22]);
            y2   = int'(rec[43:33]);
            mode = int'(rec[45:44]);
            cidx = int'(rec[48:46]);
            t    = (rec[51:49] == 3'd0) ? 1 : int'(rec[51:49]);
            if (mode == 0 || x1 > x2 || y1 > y2) continue;
            inr = (x >= x1) && (x <= x2) && (y >= y1) && (y <= y2);
            if (mode == 1) hit = inr && ((x - x1 < t) || (x2 - x < t) || (y - y1 < t) || (y2 - y < t));
            else           hit = inr;
            if (hit) return (mode == 3) ? avg565(pix, pal(cidx)) : pal(cidx);
        end
        return pix;
    endfunction

    // One clock: drive, predict, check outputs at negedge, advance the model.
    task automatic cycle(input logic vs, input logic valid, input logic [15:0] pix,
                         input logic start, input logic [BW-1:0] wire_v);
        exp_t e;
        logic fs;
        bus.i_vs        = vs;
        bus.i_valid     = valid;
        bus.i_data      = pix;
        bus.i_start     = start;
        bus.i_rect_wire = wire_v;
        if (valid) begin
            e.data = exp_pix(m_active, m_x, m_y, pix);
            e.raw  = pix;
            e.x    = m_x;
            e.y    = m_y;
            sb.push_back(e);
        end
        @(negedge sys_clk);
        check("o_valid", 16'(bus.o_valid), 16'(ev2));
        if (bus.o_valid) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow observed=o_valid expected=no_output");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("o_data(%0d,%0d)", e.x, e.y), bus.o_data, e.data);
                check($sformatf("o_data_raw(%0d,%0d)", e.x, e.y), bus.o_data_raw, e.raw);
                if (e.y < int'(IMG_H)) begin
                    cap[e.y][e.x]     = bus.o_data;
                    cap_raw[e.y][e.x] = bus.o_data_raw;
                end
            end
        end
        @(posedge sys_clk);
        fs    = vs && !m_vsq;
        m_vsq = vs;
        ev2   = ev1;
        ev1   = valid;
        if (fs) begin
            m_x = 0;
            m_y = 0;
        end else if (valid && !vs) begin
            if (m_x == int'(IMG_W) - 1) begin
                m_x = 0;
                if (m_y < int'(IMG_H)) m_y++;
            end else begin
                m_x++;
            end
        end
        if (fs) m_active = start ? wire_v : m_shadow;
        if (start) m_shadow = wire_v;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, '0);
    endtask

    task automatic frame(input int lines, input int start_line, input logic [BW-1:0] start_w,
                         input logic start_at_vs);
        logic [15:0] pix;
        cycle(1'b1, 1'b0, 16'h0, start_at_vs, start_w);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, '0);
        idle(1);
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < int'(IMG_W); x++) begin
                pix = const_en ? const_pix : 16'($urandom);
                cycle(1'b0, 1'b1, pix, (l == start_line) && (x == 7), start_w);
            end
            idle(2);
        end
        idle(2);
    endtask

    task automatic load(input logic [BW-1:0] w);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, w);
    endtask

    initial begin
        logic [BW-1:0] w;

        bus.i_vs = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
        bus.i_start = 1'b0; bus.i_rect_wire = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_o_valid", 16'(bus.o_valid), 16'h0);
        check("rst_o_data", bus.o_data, 16'h0);
        check("rst_o_data_raw", bus.o_data_raw, 16'h0);
        sys_rst = 1'b0;
        idle(2);

        // All rectangles off, random pixels.
        const_en = 1'b0;
        frame(8, -1, '0, 1'b0);
        const_en = 1'b1;

        // Outline, thickness 0.
        w = '0;
        w[0*RB +: RB] = mk(2, 2, 5, 4, 1, 1, 0);
        load(w);
        frame(8, -1, '0, 1'b0);
        check("outline(2,3)", cap[3][2], 16'hF800);
        check("outline(5,3)", cap[3][5], 16'hF800);
        check("outline(3,2)", cap[2][3], 16'hF800);
        check("interior(3,3)", cap[3][3], 16'h1234);
        check("outside(1,3)", cap[3][1], 16'h1234);
        check("raw(2,3)", cap_raw[3][2], 16'h1234);

        // Overlapping fills: lower index wins.
        w = '0;
        w[0*RB +: RB] = mk(0, 0, 3, 3, 2, 2, 0);
        w[1*RB +: RB] = mk(2, 2, 6, 6, 2, 3, 0);
        load(w);
        frame(8, -1, '0, 1'b0);
        check("prio(2,2)", cap[2][2], 16'h07E0);
        check("prio(5,5)", cap[5][5], 16'h001F);

        // Blend white over red.
        w = '0;
        w[0*RB +: RB] = mk(0, 0, 15, 7, 3, 7, 0);
        load(w);
        const_pix = 16'hF800;
        frame(8, -1, '0, 1'b0);
        check("blend(7,4)", cap[4][7], 16'hF3EF);
        const_pix = 16'h1234;

        // Mid-frame i_start only takes effect at the next frame.
        w = '0;
        w[0*RB +: RB] = mk(1, 1, 1, 1, 2, 1, 0);
        load(w);
        frame(8, -1, '0, 1'b0);
        w = '0;
        w[0*RB +: RB] = mk(9, 5, 9, 5, 2, 5, 0);
        frame(8, 3, w, 1'b0);
        check("midframe_old(1,1)", cap[1][1], 16'hF800);
        check("midframe_new(9,5)", cap[5][9], 16'h1234);
        frame(8, -1, '0, 1'b0);
        check("nextframe_new(9,5)", cap[5][9], 16'h07FF);
        check("nextframe_old(1,1)", cap[1][1], 16'h1234);

        // i_start coincident with the vs rise applies to that frame.
        w = '0;
        w[0*RB +: RB] = mk(0, 0, 0, 0, 2, 6, 0);
        frame(8, -1, w, 1'b1);
        check("vs_start(0,0)", cap[0][0], 16'hF81F);

        // Inverted record draws nothing.
        w = '0;
        w[0*RB +: RB] = mk(5, 2, 3, 4, 2, 7, 0);
        load(w);
        frame(8, -1, '0, 1'b0);
        check("inverted(4,3)", cap[3][4], 16'h1234);

        // Last-pixel rectangle, with extra lines past IMG_H.
        w = '0;
        w[0*RB +: RB] = mk(15, 7, 15, 7, 2, 4, 0);
        frame(10, -1, w, 1'b1);
        check("last(15,7)", cap[7][15], 16'hFFE0);
        check("last(14,7)", cap[7][14], 16'h1234);

        // Reset in the middle of a line.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, '0);
        idle(1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, const_pix, 1'b0, '0);
        check("pre_rst_valid", 16'(bus.o_valid), 16'h1);
        bus.i_valid = 1'b0;
        sys_rst = 1'b1;
        #1;
        check("rst_mid_o_valid", 16'(bus.o_valid), 16'h0);
        check("rst_mid_o_data", bus.o_data, 16'h0);
        sb.delete();
        ev1 = 1'b0; ev2 = 1'b0;
        m_x = 0; m_y = 0; m_vsq = 1'b0;
        m_shadow = '0; m_active = '0;
        bus.i_vs = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        idle(2);
        frame(8, -1, '0, 1'b0);
        check("after_rst(15,7)", cap[7][15], 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
